demux_1para8_8bits_reg: RTL and testbench

// - Registered 1:8 demultiplexer for 8-bit words; companion to the 8:1 word mux.
// - Accepts one word per cycle on a valid/ready input and routes it to the channel chosen by sel.
// - The word is held in that channel's output register until the consumer acknowledges it.
// - Sits between a single producer (ALU/bus side) and eight independent consumers (displays, registers).

---
 rtl/demux_pkg.sv | 21 ++
 rtl/decodificador_3para8.sv | 14 +
 rtl/demux_1para8_8bits_reg.sv | 98 +++++++++
 tb/tb_demux_1para8_8bits_reg.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared types and constants for the 1:8 word demultiplexer.
// Includes a population-count helper used for the occupancy counter.
package demux_pkg;

    localparam int unsigned N_CANAIS       = 8;
    localparam int unsigned SEL_W          = 3;
    localparam int unsigned LARGURA_PADRAO = 8;

    typedef logic [SEL_W-1:0]    canal_t;
    typedef logic [N_CANAIS-1:0] mascara_t;

    function automatic logic [3:0] conta_uns(input mascara_t m);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < N_CANAIS; i++) begin
            n = n + 4'(m[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/decodificador_3para8.sv
// 3-to-8 one-hot decoder: maps a channel index to its one-hot mask.
module decodificador_3para8
    import demux_pkg::*;
(
    input  canal_t   canal_i,
    output mascara_t mascara_o
);

    always_comb begin
        mascara_o          = '0;
        mascara_o[canal_i] = 1'b1;
    end

endmodule

// File: rtl/demux_1para8_8bits_reg.sv
// Registered 1:8 word demultiplexer with per-channel hold-until-ack registers.
// Optional macro DEMUX_AUTO_INC_EN: target is an internal round-robin pointer instead of sel.
module demux_1para8_8bits_reg
    import demux_pkg::*;
#(
    parameter int unsigned LARGURA = LARGURA_PADRAO
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [LARGURA-1:0] Entrada,
    input  logic               ent_valido,
    output logic               ent_pronto,
    input  logic [2:0]         sel,
    output logic [LARGURA-1:0] Y0,
    output logic [LARGURA-1:0] Y1,
    output logic [LARGURA-1:0] Y2,
    output logic [LARGURA-1:0] Y3,
    output logic [LARGURA-1:0] Y4,
    output logic [LARGURA-1:0] Y5,
    output logic [LARGURA-1:0] Y6,
    output logic [LARGURA-1:0] Y7,
    output logic [7:0]         sai_valido,
    input  logic [7:0]         sai_ack,
    output logic [3:0]         ocupados,
    output logic [2:0]         ponteiro
);

    logic [LARGURA-1:0] y_q [N_CANAIS];
    mascara_t           valido_q, valido_d;
    mascara_t           alvo_mask, escrita;
    logic [3:0]         ocupados_q;
    canal_t             alvo;
    logic               aceita;

`ifdef DEMUX_AUTO_INC_EN
    canal_t ptr_q, ptr_d;
    logic   unused_sel;

    assign unused_sel = ^sel;
    assign alvo       = ptr_q;
    assign ptr_d      = aceita ? ptr_q + 3'd1 : ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign alvo = sel;
`endif

    assign ponteiro = alvo;

    decodificador_3para8 u_dec (
        .canal_i   (alvo),
        .mascara_o (alvo_mask)
    );

    // A channel being acked this cycle is free to take a new word on the same edge.
    assign ent_pronto = ~valido_q[alvo] | sai_ack[alvo];
    assign aceita     = ent_valido & ent_pronto;
    assign escrita    = alvo_mask & {N_CANAIS{aceita}};

    // A write overrides a simultaneous ack on the same channel; acks on empty channels are no-ops.
    assign valido_d = escrita | (valido_q & ~sai_ack);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_CANAIS; k++) begin
                y_q[k] <= '0;
            end
            valido_q   <= '0;
            ocupados_q <= '0;
        end else begin
            for (int k = 0; k < N_CANAIS; k++) begin
                if (escrita[k]) begin
                    y_q[k] <= Entrada;
                end
            end
            valido_q   <= valido_d;
            ocupados_q <= conta_uns(valido_d);
        end
    end

    assign Y0         = y_q[0];
    assign Y1         = y_q[1];
    assign Y2         = y_q[2];
    assign Y3         = y_q[3];
    assign Y4         = y_q[4];
    assign Y5         = y_q[5];
    assign Y6         = y_q[6];
    assign Y7         = y_q[7];
    assign sai_valido = valido_q;
    assign ocupados   = ocupados_q;

endmodule

// File: tb/tb_demux_1para8_8bits_reg.sv
// Self-checking bench for demux_1para8_8bits_reg: directed scenarios plus random traffic
// compared against a channel-level behavioural model.
module tb_demux_1para8_8bits_reg;

    logic       clk;
    logic       rst_n;
    logic [7:0] Entrada;
    logic       ent_valido;
    logic       ent_pronto;
    logic [2:0] sel;
    logic [7:0] Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7;
    logic [7:0] sai_valido;
    logic [7:0] sai_ack;
    logic [3:0] ocupados;
    logic [2:0] ponteiro;

    logic [7:0] y_obs [8];
    assign y_obs[0] = Y0;
    assign y_obs[1] = Y1;
    assign y_obs[2] = Y2;
    assign y_obs[3] = Y3;
    assign y_obs[4] = Y4;
    assign y_obs[5] = Y5;
    assign y_obs[6] = Y6;
    assign y_obs[7] = Y7;

    demux_1para8_8bits_reg #(.LARGURA(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Entrada    (Entrada),
        .ent_valido (ent_valido),
        .ent_pronto (ent_pronto),
        .sel        (sel),
        .Y0         (Y0),
        .Y1         (Y1),
        .Y2         (Y2),
        .Y3         (Y3),
        .Y4         (Y4),
        .Y5         (Y5),
        .Y6         (Y6),
        .Y7         (Y7),
        .sai_valido (sai_valido),
        .sai_ack    (sai_ack),
        .ocupados   (ocupados),
        .ponteiro   (ponteiro)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: held word and full flag per channel, plus round-robin pointer.
    logic [7:0] m_y [8];
    bit         m_full [8];
    int         m_ptr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int n_full();
        int n = 0;
        for (int k = 0; k < 8; k++) if (m_full[k]) n++;
        return n;
    endfunction

    function automatic logic [7:0] full_vec();
        logic [7:0] v = '0;
        for (int k = 0; k < 8; k++) v[k] = m_full[k];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) begin
            m_y[k]    = 8'h00;
            m_full[k] = 0;
        end
        m_ptr = 0;
    endtask

    task automatic check_state(input string tag);
        for (int k = 0; k < 8; k++) chk($sformatf("%s_Y%0d", tag, k), 32'(y_obs[k]), 32'(m_y[k]));
        chk({tag, "_sai_valido"}, 32'(sai_valido), 32'(full_vec()));
        chk({tag, "_ocupados"}, 32'(ocupados), 32'(n_full()));
    endtask

    // One clock cycle: drive at the falling edge, check combinational outputs,
    // advance the model, then check registered state just after the rising edge.
    task automatic cycle(input bit v, input logic [2:0] s, input logic [7:0] d,
                         input logic [7:0] a, input string tag);
        int  t;
        bit  ready, acc;
        ent_valido = v;
        sel        = s;
        Entrada    = d;
        sai_ack    = a;
        #1;
`ifdef DEMUX_AUTO_INC_EN
        t = m_ptr;
`else
        t = int'(s);
`endif
        ready = !m_full[t] || a[t];
        acc   = v && ready;
        chk({tag, "_ent_pronto"}, 32'(ent_pronto), 32'(ready));
        chk({tag, "_ponteiro"}, 32'(ponteiro), 32'(t));
        for (int k = 0; k < 8; k++) begin
            if (acc && k == t) begin
                m_y[k]    = d;
                m_full[k] = 1;
            end else if (a[k]) begin
                m_full[k] = 0;
            end
        end
        if (acc) m_ptr = (m_ptr + 1) % 8;
        @(posedge clk);
        #1;
        check_state(tag);
        @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        Entrada    = 8'h00;
        ent_valido = 1'b0;
        sel        = 3'd0;
        sai_ack    = 8'h00;
        model_reset();
        #2;
        check_state("por");
        chk("por_ent_pronto", 32'(ent_pronto), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // First cycle after release, then a basic route to channel 5.
        cycle(1'b1, 3'd5, 8'hA7, 8'h00, "route");
        chk("route_Y5_const", 32'(Y5), 32'hA7);
        chk("route_valid_const", 32'(sai_valido), 32'h20);

        // Backpressure on channel 2: three blocked cycles, then ack frees it same cycle.
        cycle(1'b1, 3'd2, 8'h55, 8'h00, "bp_fill");
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 3'd2, 8'h66, 8'h00, "bp_block");
            chk("bp_Y2_held", 32'(Y2), 32'h55);
        end
        cycle(1'b1, 3'd2, 8'h66, 8'h04, "bp_ack");
        chk("bp_Y2_new", 32'(Y2), 32'h66);

        // Collision: ack and accept on channel 3 in the same cycle.
        cycle(1'b1, 3'd3, 8'h11, 8'h00, "col_fill");
        cycle(1'b1, 3'd3, 8'h22, 8'h08, "col");
        chk("col_Y3_const", 32'(Y3), 32'h22);

        // Drain everything, fill all eight, drain again, then ack an empty channel.
        cycle(1'b0, 3'd0, 8'h00, 8'hFF, "drain0");
        for (int k = 0; k < 8; k++) cycle(1'b1, 3'(k), 8'h30 + 8'(k), 8'h00, "fill");
        chk("fill_ocupados_const", 32'(ocupados), 32'd8);
        cycle(1'b0, 3'd0, 8'h00, 8'hFF, "drain");
        chk("drain_ocupados_const", 32'(ocupados), 32'd0);
        cycle(1'b0, 3'd0, 8'h00, 8'h01, "ack_empty");

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            logic [7:0] a;
            a = 8'($urandom) & 8'($urandom) & 8'($urandom);
            cycle(1'($urandom_range(0, 3) != 0), 3'($urandom), 8'($urandom), a, "rand");
        end

        // Asynchronous reset in the middle of traffic.
        ent_valido = 1'b1;
        sel        = 3'd6;
        Entrada    = 8'hC3;
        sai_ack    = 8'h00;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_state("rst");
        chk("rst_ent_pronto", 32'(ent_pronto), 32'd1);
        @(negedge clk);
        check_state("rst_hold");
        rst_n = 1'b1;
        cycle(1'b1, 3'd6, 8'hC3, 8'h00, "post_rst");

        for (int i = 0; i < 100; i++) begin
            cycle(1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom),
                  8'($urandom) & 8'($urandom), "rand2");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
